// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default widths for the two-client memory arbiter
//
// Contents:
//   DEF_AWIDTH / DEF_DWIDTH  default address and data widths
//   arb_state_t              arbiter FSM states
//   client_t                 client identifier used for grants
package mem_pkg;

    localparam int DEF_AWIDTH = 16;
    localparam int DEF_DWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_INS = 2'd1,
        RESP_DRD = 2'd2,
        RESP_DWR = 2'd3
    } arb_state_t;

    typedef enum logic {
        CL_INS = 1'b0,
        CL_DAT = 1'b1
    } client_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational two-way client picker
//
// Build option: MEM_ARB_RR_EN selects round-robin; otherwise fixed data-over-fetch priority.
//
// Ports:
//   ins_pend    in   fetch client has a request pending
//   dat_pend    in   data client has a read or write pending
//   last_grant  in   client granted most recently (only consulted in round-robin builds)
//   grant       out  client to serve; meaningful only when some request is pending
module arb_pick
    import mem_pkg::*;
(
    input  logic    ins_pend,
    input  logic    dat_pend,
    input  client_t last_grant,
    output client_t grant
);

`ifdef MEM_ARB_RR_EN
    // On a tie the client that did not win last time goes next.
    always_comb begin
        grant = CL_INS;
        if (ins_pend && dat_pend) begin
            grant = (last_grant == CL_INS) ? CL_DAT : CL_INS;
        end else if (dat_pend) begin
            grant = CL_DAT;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == CL_DAT);

    always_comb begin
        grant = dat_pend ? CL_DAT : CL_INS;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data client arbiter in front of one single-ported synchronous RAM
//
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (adds the last_grant register);
// without it the data client always wins over fetch.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   ins_rd_addr/req -> rdy/data       fetch client (req held until rdy)
//   dat_rw_addr, dat_wr_data,
//   dat_rd_req/dat_wr_req -> rdys     data client (write wins over a simultaneous read)
//   mem_addr/wdata/we/re, mem_rdata   RAM port, read data arrives one cycle after mem_re
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] ins_rd_addr,
    input  logic              ins_rd_req,
    output logic [DWIDTH-1:0] ins_rd_data,
    output logic              ins_rd_rdy,
    input  logic [AWIDTH-1:0] dat_rw_addr,
    input  logic [DWIDTH-1:0] dat_wr_data,
    input  logic              dat_rd_req,
    input  logic              dat_wr_req,
    output logic [DWIDTH-1:0] dat_rd_data,
    output logic              dat_rd_rdy,
    output logic              dat_wr_rdy,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DWIDTH-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    client_t    grant;
    client_t    last_grant;
    logic       ins_pend;
    logic       dat_pend;
    logic       granting;

    assign ins_pend = ins_rd_req;
    assign dat_pend = dat_rd_req | dat_wr_req;

    // A grant only happens in IDLE; RESP_* cycles ignore the still-asserted request.
    // reset_n gates it so the RAM port stays quiet while reset is held.
    assign granting = reset_n && (state == IDLE) && (ins_pend || dat_pend);

    arb_pick u_pick (
        .ins_pend   (ins_pend),
        .dat_pend   (dat_pend),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef MEM_ARB_RR_EN
    // Reset value makes the first tie after reset go to the fetch client.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= CL_DAT;
        end else if (granting) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = CL_DAT;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (granting) begin
            if (grant == CL_INS) begin
                mem_addr  = ins_rd_addr;
                mem_re    = 1'b1;
                state_nxt = RESP_INS;
            end else if (dat_wr_req) begin
                mem_addr  = dat_rw_addr;
                mem_wdata = dat_wr_data;
                mem_we    = 1'b1;
                state_nxt = RESP_DWR;
            end else begin
                mem_addr  = dat_rw_addr;
                mem_re    = 1'b1;
                state_nxt = RESP_DRD;
            end
        end
    end

    // Completion pulses decode straight from the registered state; every RESP_* lasts one cycle.
    assign ins_rd_rdy  = (state == RESP_INS);
    assign dat_rd_rdy  = (state == RESP_DRD);
    assign dat_wr_rdy  = (state == RESP_DWR);
    assign ins_rd_data = ins_rd_rdy ? mem_rdata : '0;
    assign dat_rd_data = dat_rd_rdy ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ins_rd_addr;
    logic        ins_rd_req;
    logic [15:0] ins_rd_data;
    logic        ins_rd_rdy;
    logic [15:0] dat_rw_addr;
    logic [15:0] dat_wr_data;
    logic        dat_rd_req;
    logic        dat_wr_req;
    logic [15:0] dat_rd_data;
    logic        dat_rd_rdy;
    logic        dat_wr_rdy;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0000;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ins_rd_addr (ins_rd_addr),
        .ins_rd_req  (ins_rd_req),
        .ins_rd_data (ins_rd_data),
        .ins_rd_rdy  (ins_rd_rdy),
        .dat_rw_addr (dat_rw_addr),
        .dat_wr_data (dat_wr_data),
        .dat_rd_req  (dat_rd_req),
        .dat_wr_req  (dat_wr_req),
        .dat_rd_data (dat_rd_data),
        .dat_rd_rdy  (dat_rd_rdy),
        .dat_wr_rdy  (dat_wr_rdy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
    );

    // RAM attached to the DUT, and the model's own view of memory contents.
    logic [15:0] ram       [0:65535];
    logic [15:0] model_mem [0:65535];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Transaction model: a single slot that is either free or holding one granted access
    // whose completion is due in the following cycle.
    bit          m_busy     = 1'b0;
    int          m_kind     = 0;      // 0 fetch, 1 data read, 2 data write
    logic [15:0] m_addr     = 16'h0;
    bit          m_last_dat = 1'b1;
    int          we_pulses  = 0;
    int          drd_pulses = 0;
    logic [15:0] grant_addr_q [$];
    int          grant_cyc_q  [$];

    always @(negedge clk) begin
        logic        e_re, e_we, e_irdy, e_drdy, e_wrdy;
        logic [15:0] e_addr, e_wd, e_id, e_dd;
        bit          take_dat;
        e_re = 1'b0; e_we = 1'b0; e_irdy = 1'b0; e_drdy = 1'b0; e_wrdy = 1'b0;
        e_addr = 16'h0; e_wd = 16'h0; e_id = 16'h0; e_dd = 16'h0;
        if (!reset_n) begin
            m_busy     = 1'b0;
            m_last_dat = 1'b1;
        end else if (m_busy) begin
            if (m_kind == 0) begin
                e_irdy = 1'b1; e_id = model_mem[m_addr];
            end else if (m_kind == 1) begin
                e_drdy = 1'b1; e_dd = model_mem[m_addr];
            end else begin
                e_wrdy = 1'b1;
            end
            m_busy = 1'b0;
        end else if (ins_rd_req || dat_rd_req || dat_wr_req) begin
`ifdef MEM_ARB_RR_EN
            take_dat = (dat_rd_req || dat_wr_req) && (!ins_rd_req || !m_last_dat);
`else
            take_dat = dat_rd_req || dat_wr_req;
`endif
            if (!take_dat) begin
                m_kind = 0; m_addr = ins_rd_addr; e_re = 1'b1;
            end else if (dat_wr_req) begin
                m_kind = 2; m_addr = dat_rw_addr; e_we = 1'b1; e_wd = dat_wr_data;
                model_mem[dat_rw_addr] = dat_wr_data;
            end else begin
                m_kind = 1; m_addr = dat_rw_addr; e_re = 1'b1;
            end
            e_addr     = m_addr;
            m_last_dat = take_dat;
            m_busy     = 1'b1;
        end
        chk_b("mem_re", mem_re, e_re);
        chk_b("mem_we", mem_we, e_we);
        chk_w("mem_addr", mem_addr, e_addr);
        chk_w("mem_wdata", mem_wdata, e_wd);
        chk_b("ins_rd_rdy", ins_rd_rdy, e_irdy);
        chk_w("ins_rd_data", ins_rd_data, e_id);
        chk_b("dat_rd_rdy", dat_rd_rdy, e_drdy);
        chk_w("dat_rd_data", dat_rd_data, e_dd);
        chk_b("dat_wr_rdy", dat_wr_rdy, e_wrdy);
        if (mem_re || mem_we) begin
            grant_addr_q.push_back(mem_addr);
            grant_cyc_q.push_back(cyc);
        end
        if (mem_we) we_pulses++;
        if (dat_rd_rdy) drd_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives until every raised request has been served, dropping each one after its rdy.
    task automatic run_reqs(input int maxc, output int wr_c, output int rd_c,
                            output logic [15:0] rd_v);
        int n;
        bit g_in, g_rd, g_wr;
        n = 0; wr_c = -1; rd_c = -1; rd_v = 16'h0;
        while ((ins_rd_req || dat_rd_req || dat_wr_req) && n < maxc) begin
            @(negedge clk);
            g_in = ins_rd_rdy; g_rd = dat_rd_rdy; g_wr = dat_wr_rdy;
            if (g_rd) begin rd_c = cyc; rd_v = dat_rd_data; end
            if (g_wr) wr_c = cyc;
            @(posedge clk);
            #1;
            if (g_in) ins_rd_req = 1'b0;
            if (g_rd) dat_rd_req = 1'b0;
            if (g_wr) dat_wr_req = 1'b0;
            n++;
        end
        chk_b("run_reqs_ins_done", ins_rd_req, 1'b0);
        chk_b("run_reqs_drd_done", dat_rd_req, 1'b0);
        chk_b("run_reqs_dwr_done", dat_wr_req, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_c, rd_c, g, n0, d0;
        logic [15:0] rd_v;
        logic [15:0] exp_a [4];

        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'h0;
            model_mem[i] = 16'h0;
        end
        ram[16'h0010] = 16'h1234;
        model_mem[16'h0010] = 16'h1234;

        reset_n = 1'b0;
        ins_rd_addr = 16'h0055; ins_rd_req = 1'b1;
        dat_rw_addr = 16'h0; dat_wr_data = 16'h0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;

        // Reset holds the RAM port quiet even with a request present.
        @(negedge clk);
        chk_b("rst_mem_re", mem_re, 1'b0);
        chk_w("rst_mem_addr", mem_addr, 16'h0000);
        chk_b("rst_ins_rdy", ins_rd_rdy, 1'b0);
        tick();
        ins_rd_req = 1'b0;
        tick();
        reset_n = 1'b1;
        while (cyc < 5) tick();

        // Fetch only, request at cycle 5.
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        @(negedge clk);
        chk_i("fetch_grant_cyc", cyc, 5);
        chk_b("fetch_mem_re", mem_re, 1'b1);
        chk_w("fetch_mem_addr", mem_addr, 16'h0010);
        tick();
        @(negedge clk);
        chk_b("fetch_rdy", ins_rd_rdy, 1'b1);
        chk_w("fetch_data", ins_rd_data, 16'h1234);
        tick();
        ins_rd_req = 1'b0;
        @(negedge clk);
        chk_b("fetch_rdy_gone", ins_rd_rdy, 1'b0);
        chk_b("fetch_no_regrant", mem_re, 1'b0);
        tick();

        // Write then read back.
        d0 = we_pulses;
        dat_rw_addr = 16'h0100; dat_wr_data = 16'hBEEF; dat_wr_req = 1'b1;
        run_reqs(10, wr_c, rd_c, rd_v);
        g = grant_cyc_q[$];
        chk_i("wr_rdy_latency", wr_c - g, 1);
        chk_i("wr_we_pulses", we_pulses - d0, 1);
        dat_rd_req = 1'b1;
        run_reqs(10, wr_c, rd_c, rd_v);
        chk_w("readback_data", rd_v, 16'hBEEF);

        // Simultaneous read and write to one address: write first, read in the next IDLE.
        dat_rw_addr = 16'h0200; dat_wr_data = 16'h7777; dat_rd_req = 1'b1; dat_wr_req = 1'b1;
        run_reqs(10, wr_c, rd_c, rd_v);
        chk_i("rw_order_gap", rd_c - wr_c, 2);
        chk_w("rw_read_data", rd_v, 16'h7777);

        // Contention: both held for eight cycles.
        n0 = grant_addr_q.size();
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        dat_rw_addr = 16'h0100; dat_rd_req = 1'b1;
`ifdef MEM_ARB_RR_EN
        exp_a = '{16'h0010, 16'h0100, 16'h0010, 16'h0100};
`else
        exp_a = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
`endif
        repeat (8) tick();
        chk_i("cont_grants", grant_addr_q.size() - n0, 4);
        if (grant_addr_q.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk_w("cont_grant_addr", grant_addr_q[n0 + k], exp_a[k]);
                if (k > 0) chk_i("cont_spacing", grant_cyc_q[n0 + k] - grant_cyc_q[n0 + k - 1], 2);
            end
        end
        dat_rd_req = 1'b0;
        tick();
        chk_w("cont_ins_after_drop", grant_addr_q[$], 16'h0010);
        ins_rd_req = 1'b0;
        tick();

        // Reset while a data read is in its response cycle.
        d0 = drd_pulses;
        dat_rw_addr = 16'h0100; dat_rd_req = 1'b1;
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk_b("rst_mid_drd_rdy", dat_rd_rdy, 1'b0);
        chk_w("rst_mid_drd_data", dat_rd_data, 16'h0000);
        chk_b("rst_mid_mem_re", mem_re, 1'b0);
        chk_w("rst_mid_mem_addr", mem_addr, 16'h0000);
        tick();
        dat_rd_req = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk_i("rst_mid_no_drd_rdy", drd_pulses - d0, 0);
        ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
        @(negedge clk);
        chk_b("post_rst_mem_re", mem_re, 1'b1);
        tick();
        @(negedge clk);
        chk_b("post_rst_rdy", ins_rd_rdy, 1'b1);
        chk_w("post_rst_data", ins_rd_data, 16'h1234);
        tick();
        ins_rd_req = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client memory arbiter that lets the cpu16 instruction-fetch port and data port share one single-ported simram. It sits directly downstream of cpu16, in place of the separate instruction and data RAMs. It speaks the cpu16 req/rdy handshake on both client sides and drives a synchronous one-cycle-read-latency RAM port. It serialises accesses, with at most one RAM operation in flight.

## Interface
- AWIDTH, 16, address width of both clients and the RAM
- DWIDTH, 16, data width
- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- ins_rd_addr  input  AWIDTH  fetch address, held stable while ins_rd_req is high
- ins_rd_req  input  1  fetch request, held until ins_rd_rdy
- ins_rd_data  output  DWIDTH  fetch data, valid only in the ins_rd_rdy cycle
- ins_rd_rdy  output  1  one-cycle completion pulse for a fetch
- dat_rw_addr  input  AWIDTH  data address, held stable while a data req is high
- dat_wr_data  input  DWIDTH  write data, held stable with dat_wr_req
- dat_rd_req  input  1  data read request
- dat_wr_req  input  1  data write request
- dat_rd_data  output  DWIDTH  read data, valid only in the dat_rd_rdy cycle
- dat_rd_rdy  output  1  one-cycle completion pulse for a data read
- dat_wr_rdy  output  1  one-cycle completion pulse for a data write
- mem_addr  output  AWIDTH  RAM address
- mem_wdata  output  DWIDTH  RAM write data
- mem_we  output  1  RAM write enable
- mem_re  output  1  RAM read enable
- mem_rdata  input  DWIDTH  RAM read data, valid one cycle after mem_re

## Operation
- FSM states:
  - IDLE
  - RESP_INS
  - RESP_DRD
  - RESP_DWR
- IDLE, no request pending:
  - mem_re=0, mem_we=0
  - mem_addr=0, mem_wdata=0
- IDLE, request pending:
  - Picks one client and issues its RAM operation combinationally in the same cycle.
  - Moves to the matching RESP_* state on the next edge.
- Issue rules:
  - Fetch: mem_addr=ins_rd_addr, mem_re=1.
  - Data read: mem_addr=dat_rw_addr, mem_re=1.
  - Data write: mem_addr=dat_rw_addr, mem_wdata=dat_wr_data, mem_we=1.
- RESP_* states:
  - The matching rdy is high for exactly one cycle.
  - Read data is forwarded combinationally: ins_rd_data/dat_rd_data = mem_rdata.
  - No RAM operation is issued.
  - Next state is always IDLE.
  - The client still shows req in this cycle; it must not be re-granted.
- Arbitration, both clients pending: see Configuration.
- dat_rd_req and dat_wr_req both high: the write is taken and the read stays pending.
- Requests that drop before being granted are simply not served. This is not an error.
- Read-data outputs are 0 outside their rdy cycle.

## Timing
- Reset (reset_n low):
  - State goes to IDLE immediately (asynchronous).
  - All rdy outputs are 0.
  - mem_re, mem_we, mem_addr and mem_wdata are 0 while reset_n is low.
  - The round-robin pointer resets to "data last granted", so the first tie goes to ins.
- Reset mid-transaction drops the operation:
  - No rdy is produced.
  - A write already issued in the grant cycle stands in RAM.
- Latency: request seen in IDLE at cycle T gives rdy at T+1; the next grant can happen at T+2.
- Throughput: one access per 2 cycles; this holds for any client mix.
- Rdy and state are registered; mem_* are combinational from state and request inputs.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration. When both clients are pending in IDLE, the client not granted last wins.
  - A last_grant register updates on every grant.
- MEM_ARB_RR_EN undefined:
  - Fixed priority, data client always over fetch.
  - No last_grant register exists.

## Structure
- Shared package mem_pkg holds:
  - arb_state_t enum (IDLE, RESP_INS, RESP_DRD, RESP_DWR)
  - client_t enum (CL_INS, CL_DAT)
  - default AWIDTH/DWIDTH localparams
- Sub-module arb_pick:
  - Combinational two-way picker.
  - Inputs: ins_pend, dat_pend, last_grant.
  - Output: grant (client_t).
  - Contains the MEM_ARB_RR_EN conditional so mem_arbiter's FSM is identical in both builds.

## Test plan
- Fetch only: ins_rd_req=1 with addr 0x0010 at cycle 5, RAM[0x0010]=0x1234.
  - mem_re=1 with mem_addr=0x0010 at cycle 5.
  - ins_rd_rdy=1 with ins_rd_data=0x1234 at cycle 6 only.
- Write then read back: dat_wr_req addr 0x0100 data 0xBEEF, then dat_rd_req 0x0100.
  - mem_we pulses once.
  - dat_wr_rdy comes one cycle after the grant.
  - The later dat_rd_rdy returns 0xBEEF.
- Contention:
  - Both clients request continuously.
  - With MEM_ARB_RR_EN: grants alternate INS, DAT, INS, … at cycles T, T+2, T+4.
  - Without it: DAT is served repeatedly and INS is starved until dat req drops.
- Simultaneous dat_rd_req and dat_wr_req:
  - The write completes first (dat_wr_rdy).
  - The read is granted in the next IDLE.
  - No cycle has mem_re and mem_we both high.
- Reset mid-operation: reset_n low during RESP_DRD.
  - dat_rd_rdy never asserts.
  - All outputs are 0 in the same cycle.
  - After release, a new request completes normally with 1-cycle latency.
- Back-to-back from cpu16 bench: run the program to the 0xFFFF sentinel over the shared RAM.
  - Register dump matches the dual-RAM build.
